// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: the layout of the
// display register and the hex-to-segment lookup table.
package seg7_pkg;

  // Display register field positions
  localparam int NIB_LSB   = 0;   // four 4-bit digit nibbles, digit 0 lowest
  localparam int DP_LSB    = 16;  // one decimal-point bit per digit
  localparam int BLANK_LSB = 20;  // one blank bit per digit
  localparam int EN_BIT    = 24;  // global display enable

  // Bits [31:25] are reserved: masked on write so they always read back 0
  localparam logic [31:0] REG_MASK = 32'h01FF_FFFF;

  // Segment patterns in gfedcba order, active-high, indexed by nibble value
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/seg7_scan_driver_hex7_decode.sv
// Combinational hex digit to seven-segment (gfedcba) decoder.
module hex7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Straight table lookup; every nibble value has a defined glyph
  always_comb begin
    segs = HEX7_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Memory-mapped four-digit seven-segment display controller.
// The CPU writes one packed display word; the block scans the digits with a
// prescaled counter and drives registered one-hot select and segment lines.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,  // clk cycles each digit is held, >= 2
  parameter int DIGITS   = 4        // fixed by the register layout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValueRead,
  input  logic        ValueWrite,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic [3:0]  sel,
  output logic [7:0]  seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

  // Architectural state
  logic [31:0]       disp_reg;
  logic [PW-1:0]     pcnt_reg, pcnt_next;
  logic [1:0]        idx_reg, idx_next;
  logic [3:0]        sel_reg, sel_next;
  logic [7:0]        seg_reg, seg_next;

  // Decoded views of the display register
  logic [3:0]        nib     [DIGITS];
  logic [6:0]        dec     [DIGITS];
  logic [DIGITS-1:0] dp_bits;
  logic [DIGITS-1:0] blank_bits;
  logic              enable;
  logic              tick;

  assign dp_bits    = disp_reg[DP_LSB +: DIGITS];
  assign blank_bits = disp_reg[BLANK_LSB +: DIGITS];
  assign enable     = disp_reg[EN_BIT];

  // One decoder per digit so the output mux selects a finished pattern
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi] = disp_reg[NIB_LSB + 4*gi +: 4];

      hex7_decode u_hex7 (
        .nibble (nib[gi]),
        .segs   (dec[gi])
      );
    end
  endgenerate

  // Prescaler, digit index and next output pattern; outputs only move on tick
  always_comb begin
    tick      = (pcnt_reg == PCNT_MAX);
    pcnt_next = tick ? '0 : pcnt_reg + PW'(1);
    idx_next  = tick ? idx_reg + 2'd1 : idx_reg;
    sel_next  = sel_reg;
    seg_next  = seg_reg;
    if (tick) begin
      if (!enable) begin
        sel_next = 4'b0000;
        seg_next = 8'h00;
      end else begin
        sel_next = 4'b0001 << idx_next;
        if (blank_bits[idx_next]) begin
          seg_next = 8'h00;
        end else begin
          seg_next = {dp_bits[idx_next], dec[idx_next]};
        end
      end
    end
  end

  // State registers; reset wins over a same-cycle bus write
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_reg <= '0;
      pcnt_reg <= '0;
      idx_reg  <= '0;
      sel_reg  <= '0;
      seg_reg  <= '0;
    end else begin
      if (ValueWrite) begin
        disp_reg <= Write_data & REG_MASK;
      end
      pcnt_reg <= pcnt_next;
      idx_reg  <= idx_next;
      sel_reg  <= sel_next;
      seg_reg  <= seg_next;
    end
  end

  // Read port returns the current (pre-edge) register contents
  assign Read_data = ValueRead ? disp_reg : 32'h0000_0000;
  assign sel       = sel_reg;
  assign seg       = seg_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with SCAN_DIV=4.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ValueRead = 1'b0;
  logic        ValueWrite = 1'b0;
  logic [31:0] Write_data = 32'h0;
  logic [31:0] Read_data;
  logic [3:0]  sel;
  logic [7:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;
  int ph      = 0;   // expected prescaler phase after the last edge
  int cur_idx = 0;   // expected digit index after the last edge

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [31:0] tbl_words [4] = '{
    32'h0105_3210, 32'h0105_7654, 32'h0105_BA98, 32'h0105_FEDC
  };

  // Scan order after the first write: digits 2,3,0,1,2 of 0x1234
  logic [3:0] scan_sel [5] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  logic [7:0] scan_seg [5] = '{8'h5B, 8'h06, 8'h66, 8'h4F, 8'h5B};

  seg7_scan_driver #(.SCAN_DIV(4), .DIGITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ValueRead  (ValueRead),
    .ValueWrite (ValueWrite),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .sel        (sel),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock and update the expected scan phase and index
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      ph = 0;
      cur_idx = 0;
    end else if (ph == 3) begin
      ph = 0;
      cur_idx = (cur_idx + 1) % 4;
    end else begin
      ph = ph + 1;
    end
  endtask

  // Advance until the edge that performed a tick (at most four clocks)
  task automatic next_tick();
    step();
    while (ph != 0) step();
  endtask

  task automatic bus_write(input logic [31:0] w);
    ValueWrite = 1'b1;
    Write_data = w;
    step();
    ValueWrite = 1'b0;
  endtask

  function automatic logic [3:0] one_hot(input int d);
    logic [3:0] v;
    v = 4'b0001;
    return v << d;
  endfunction

  function automatic logic [7:0] lit(input logic [31:0] w, input int d);
    logic [3:0] n;
    n = w[4*d +: 4];
    return {w[16+d], hex_tab[n]};
  endfunction

  logic [31:0] w;
  int          d;

  initial begin
    // Reset with a competing write: reset must win
    reset = 1'b1;
    ValueWrite = 1'b1;
    Write_data = 32'hFFFF_FFFF;
    repeat (3) step();
    reset = 1'b0;
    ValueWrite = 1'b0;
    ValueRead = 1'b1;
    check_val("rst_sel", {28'h0, sel}, 32'h0);
    check_val("rst_seg", {24'h0, seg}, 32'h0);
    check_val("rst_read", Read_data, 32'h0);

    // First tick with disp=0 keeps everything dark
    next_tick();
    check_val("tick0_sel", {28'h0, sel}, 32'h0);
    check_val("tick0_seg", {24'h0, seg}, 32'h0);

    // Write 0x0100_1234: read shows old value same cycle, new value after
    ValueWrite = 1'b1;
    Write_data = 32'h0100_1234;
    check_val("wr_read_old", Read_data, 32'h0);
    step();
    ValueWrite = 1'b0;
    check_val("wr_read_new", Read_data, 32'h0100_1234);
    check_val("wr_no_middigit", {28'h0, sel}, 32'h0);

    // Scan order and four-cycle hold per digit, including wrap 3->0
    for (int k = 0; k < 5; k++) begin
      next_tick();
      check_val($sformatf("scan%0d_sel", k), {28'h0, sel}, {28'h0, scan_sel[k]});
      check_val($sformatf("scan%0d_seg", k), {24'h0, seg}, {24'h0, scan_seg[k]});
      for (int h = 0; h < 3; h++) begin
        step();
        check_val($sformatf("hold%0d_%0d_sel", k, h), {28'h0, sel}, {28'h0, scan_sel[k]});
        check_val($sformatf("hold%0d_%0d_seg", k, h), {24'h0, seg}, {24'h0, scan_seg[k]});
      end
    end

    // Full hex table sweep; dp=0101 lights digits 0 and 2 only
    for (int i = 0; i < 4; i++) begin
      w = tbl_words[i];
      bus_write(w);
      for (int k = 0; k < 4; k++) begin
        next_tick();
        d = cur_idx;
        check_val($sformatf("tbl%0d_d%0d_sel", i, d), {28'h0, sel}, {28'h0, one_hot(d)});
        check_val($sformatf("tbl%0d_d%0d_seg", i, d), {24'h0, seg}, {24'h0, lit(w, d)});
      end
    end

    // Mid-digit write one cycle after a tick: old pattern for 3 more cycles
    d = cur_idx;
    bus_write(32'h0100_0000);
    for (int h = 0; h < 3; h++) begin
      if (h > 0) step();
      check_val($sformatf("mid_hold%0d_sel", h), {28'h0, sel}, {28'h0, one_hot(d)});
      check_val($sformatf("mid_hold%0d_seg", h), {24'h0, seg}, {24'h0, lit(32'h0105_FEDC, d)});
    end
    step();
    check_val("mid_new_ph", ph, 0);
    check_val("mid_new_sel", {28'h0, sel}, {28'h0, one_hot(cur_idx)});
    check_val("mid_new_seg", {24'h0, seg}, 32'h3F);

    // All digits blanked: select still walks, segments dark
    bus_write(32'h01F0_ABCD);
    for (int k = 0; k < 4; k++) begin
      next_tick();
      check_val($sformatf("blank%0d_sel", k), {28'h0, sel}, {28'h0, one_hot(cur_idx)});
      check_val($sformatf("blank%0d_seg", k), {24'h0, seg}, 32'h0);
    end

    // Clearing enable takes effect at the next tick, not immediately
    d = cur_idx;
    bus_write(32'h0000_ABCD);
    check_val("dis_held_sel", {28'h0, sel}, {28'h0, one_hot(d)});
    next_tick();
    check_val("dis_sel", {28'h0, sel}, 32'h0);
    check_val("dis_seg", {24'h0, seg}, 32'h0);
    next_tick();
    check_val("dis2_sel", {28'h0, sel}, 32'h0);

    // Re-enable: counters kept running while disabled
    bus_write(32'h0100_0000);
    next_tick();
    check_val("reen_sel", {28'h0, sel}, {28'h0, one_hot(cur_idx)});
    check_val("reen_seg", {24'h0, seg}, 32'h3F);

    // Read/write collision with reserved bits set
    ValueWrite = 1'b1;
    Write_data = 32'hFFFF_FFFF;
    check_val("coll_read_old", Read_data, 32'h0100_0000);
    step();
    ValueWrite = 1'b0;
    check_val("coll_read_new", Read_data, 32'h01FF_FFFF);

    // Reset mid-scan with a competing write; scan restarts from digit 1
    reset = 1'b1;
    ValueWrite = 1'b1;
    Write_data = 32'h0100_8888;
    step();
    reset = 1'b0;
    ValueWrite = 1'b0;
    check_val("rst2_read", Read_data, 32'h0);
    check_val("rst2_sel", {28'h0, sel}, 32'h0);
    check_val("rst2_seg", {24'h0, seg}, 32'h0);
    bus_write(32'h0100_1234);
    step();
    check_val("rst2_c2_sel", {28'h0, sel}, 32'h0);
    step();
    check_val("rst2_c3_sel", {28'h0, sel}, 32'h0);
    step();
    check_val("rst2_first_sel", {28'h0, sel}, 32'h2);
    check_val("rst2_first_seg", {24'h0, seg}, 32'h4F);
    step();
    check_val("rst2_hold_sel", {28'h0, sel}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
